// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data stages, data first.
// Define ARB_TIMEOUT_EN to abort BUSY accesses after TIMEOUT cycles without MemAck.
module unified_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_IWAIT = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRData,
    output logic              IValid,
    output logic              IStall,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic [DATA_W-1:0] DRData,
    output logic              DValid,
    output logic              DStall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    output logic              BusErr
);
    localparam int IW = $clog2(MAX_IWAIT + 1);
    localparam logic [IW-1:0] IW_MAX = IW'(MAX_IWAIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
    logic              ivalid_q, ivalid_d, dvalid_q, dvalid_d, buserr_q, buserr_d;
    logic [IW-1:0]     iwait_q, iwait_d;
    logic              busy, tmo_hit, done, i_gnt;
    logic [DATA_W-1:0] rdata;

    assign busy = state_q == BUSY_I || state_q == BUSY_D;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    assign tmo_hit = busy && tmo_q == TMO_MAX;
    assign tmo_d   = busy ? tmo_q + 1'b1 : '0;
    always_ff @(posedge CLK) begin
        tmo_q <= RST ? '0 : tmo_d;
    end
`else
    // no timeout: BUSY waits for MemAck forever
    assign tmo_hit = TIMEOUT < 0;
`endif

    assign done  = busy && (MemAck || tmo_hit);
    assign rdata = MemAck ? MemRData : DATA_W'(32'hDEADBEEF);
    assign i_gnt = IReq && (!DReq || iwait_q == IW_MAX);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        iwait_d     = iwait_q;
        ivalid_d    = done && state_q == BUSY_I;
        dvalid_d    = done && state_q == BUSY_D;
        buserr_d    = done && !MemAck;
        if (state_q == IDLE && i_gnt) begin
            state_d    = BUSY_I;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = IAddr;
            iwait_d    = '0;
        end else if (state_q == IDLE && DReq) begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = DWe;
            mem_addr_d  = DAddr;
            mem_wdata_d = DWData;
            iwait_d     = (IReq && iwait_q != IW_MAX) ? iwait_q + 1'b1 : iwait_q;
        end else if (done) begin
            state_d   = RESP;
            mem_req_d = 1'b0;
            irdata_d  = ivalid_d ? rdata : irdata_q;
            drdata_d  = dvalid_d ? rdata : drdata_q;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            buserr_q    <= 1'b0;
            iwait_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            ivalid_q    <= ivalid_d;
            dvalid_q    <= dvalid_d;
            buserr_q    <= buserr_d;
            iwait_q     <= iwait_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign IRData   = irdata_q;
    assign DRData   = drdata_q;
    assign IValid   = ivalid_q;
    assign DValid   = dvalid_q;
    assign BusErr   = buserr_q;
    assign IStall   = IReq && !ivalid_q;
    assign DStall   = DReq && !dvalid_q;
endmodule
